writeback_regfile: RTL
======================

Name: writeback_regfile

Overview:
- Decode/write-back stage of the SEQ Y86-64 core: a 15-entry 64-bit register file with decode-side source/destination selection, sitting directly downstream of the memory stage.
- Consumes valE (execute) and valM (memory) and commits them on the clock edge.
- Supplies valA/valB combinationally to execute/memory.
- Holds the architectural status state machine, which freezes commits once a non-AOK status retires, and a retired-instruction counter.

Parameters:
- NREG, 15, number of architectural registers (0..14); ID 4'hF = RNONE.
- RSP_ID, 4, register ID of %rsp.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- icode  input  4  instruction code of the current instruction.
- rA  input  4  rA field.
- rB  input  4  rB field.
- cnd  input  1  condition flag from execute (used by cmovXX).
- valE  input  64  ALU result.
- valM  input  64  memory read data.
- stat_in  input  3  status of the current instruction: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- valA  output  64  read port A data.
- valB  output  64  read port B data.
- dstE  output  4  E-write destination (RNONE if none).
- dstM  output  4  M-write destination (RNONE if none).
- stat_out  output  3  latched architectural status.
- halted  output  1  high once the core has stopped.
- instr_count  output  64  number of instructions committed.

Behaviour:
- srcA selection:
  - rA for icode 2, 4, 6, A.
  - RSP_ID for 9, B.
  - else RNONE.
- srcB selection:
  - rB for 4, 5, 6.
  - RSP_ID for 8, 9, A, B.
  - else RNONE.
- dstE selection:
  - icode 2: rB if cnd=1, else RNONE.
  - icode 3, 6: rB.
  - icode 8, 9, A, B: RSP_ID.
  - else RNONE.
- dstM selection: rA for icode 5, B; else RNONE.
- Reads are combinational: valA = reg[srcA], valB = reg[srcB]. A source of RNONE (or any ID >= NREG) reads 0.
- Status FSM, two states:
  - RUN (reset state): stat_out = 1, halted = 0.
  - STOP: stat_out holds the status that caused entry; halted = 1.
- In RUN, at a posedge with stat_in = AOK:
  - reg[dstE] <= valE if dstE != RNONE.
  - reg[dstM] <= valM if dstM != RNONE.
  - instr_count increments by 1.
- In RUN, at a posedge with stat_in != AOK:
  - No register writes.
  - stat_out <= stat_in; transition to STOP.
  - instr_count increments only when stat_in = HLT (halt counts as retired; ADR/INS do not).
- STOP:
  - All writes and counting are suppressed regardless of inputs.
  - Exit only via rst.
  - Reads remain live.
- Simultaneous write conflict (dstE == dstM, e.g. popq %rsp): valM wins.
- Write-to-ID >= NREG other than RNONE: ignored.
- Reset (synchronous):
  - All registers <= 0, stat_out <= 1, halted <= 0, instr_count <= 0.
  - rst has priority over any commit in the same cycle.
  - Reset asserted while in STOP returns to RUN.
- instr_count wraps modulo 2^64.
- Read-during-write: without the optional feature, valA/valB show the old value until the edge, and the new value afterwards.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - valA/valB take combinational forwarding from the same-cycle write data: if srcX == dstM, use valM; else if srcX == dstE, use valE.
  - Forwarding applies only when the write would actually commit (RUN and stat_in = AOK) and srcX != RNONE.
  - M priority matches the write rule.
- Undefined: pure register-file read, as in Behaviour.

Test Plan:
- Reset, then irmovq (icode 3, rB=2, valE=0x1234) -> after edge reg2=0x1234, instr_count=1; valA/valB for RNONE read 0.
- popq %rsp (icode B, rA=4, valE=0x108, valM=0xDEAD) -> dstE=4, dstM=4; after edge reg4=0xDEAD; instr_count increments.
- cmovXX (icode 2, rA=2, rB=3, valE=0x55) with cnd=0 -> dstE=RNONE, reg3 unchanged. Repeat with cnd=1 -> reg3=0x55.
- Instruction with stat_in=3 (ADR), icode 6, rB=1, valE=7 -> reg1 unchanged, stat_out=3, halted=1, count unchanged. Subsequent AOK irmovq -> no write. rst -> stat_out=1, halted=0, all regs 0.
- halt (icode 0, stat_in=2) after 5 committed instructions -> instr_count=6, stat_out=2, halted=1.
- With WB_BYPASS_EN: OPq (icode 6, rA=2, rB=2, valE=0x99) while reg2=0x10 -> valB=0x99 before the edge. Without the macro -> valB=0x10 before the edge, 0x99 after.

Source files
------------

// File: rtl/writeback_regfile.sv
// Y86-64 SEQ decode/write-back stage: 15x64 register file, status FSM, retired-instruction counter.
// Optional macro WB_BYPASS_EN forwards same-cycle write data onto the read ports.
module writeback_regfile #(
    parameter int NREG   = 15,
    parameter int RSP_ID = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic [2:0]  stat_in,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [2:0]  stat_out,
    output logic        halted,
    output logic [63:0] instr_count
);

    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'(RSP_ID);
    localparam logic [2:0] AOK   = 3'd1;
    localparam logic [2:0] HLT   = 3'd2;
    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] STOP  = 1'b1;

    logic [63:0] regs [NREG];
    logic [0:0]  state;
    logic [2:0]  stat_reg;
    logic [63:0] count;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic        commit;

    always_comb begin
        src_a = RNONE;
        case (icode)
            4'h2, 4'h4, 4'h6, 4'hA: src_a = rA;
            4'h9, 4'hB:             src_a = RSP;
            default:                src_a = RNONE;
        endcase
    end

    always_comb begin
        src_b = RNONE;
        case (icode)
            4'h4, 4'h5, 4'h6:       src_b = rB;
            4'h8, 4'h9, 4'hA, 4'hB: src_b = RSP;
            default:                src_b = RNONE;
        endcase
    end

    always_comb begin
        dstE = RNONE;
        case (icode)
            4'h2:                   dstE = cnd ? rB : RNONE;
            4'h3, 4'h6:             dstE = rB;
            4'h8, 4'h9, 4'hA, 4'hB: dstE = RSP;
            default:                dstE = RNONE;
        endcase
    end

    always_comb begin
        dstM = RNONE;
        case (icode)
            4'h5, 4'hB: dstM = rA;
            default:    dstM = RNONE;
        endcase
    end

    assign commit = (state == RUN) && (stat_in == AOK);

    // IDs outside the file (including RNONE) match no entry and read as zero.
    function automatic logic [63:0] rd(input logic [3:0] id);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) begin
            if (id == 4'(i)) r = regs[i];
        end
        return r;
    endfunction

`ifdef WB_BYPASS_EN
    // M-port data outranks E-port data, matching the commit priority.
    function automatic logic [63:0] fwd(input logic [3:0] id);
        logic [63:0] r;
        r = rd(id);
        if (commit && id != RNONE) begin
            if (id == dstM)      r = valM;
            else if (id == dstE) r = valE;
        end
        return r;
    endfunction

    assign valA = fwd(src_a);
    assign valB = fwd(src_b);
`else
    assign valA = rd(src_a);
    assign valB = rd(src_b);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            state    <= RUN;
            stat_reg <= AOK;
            count    <= '0;
        end else if (state == RUN) begin
            if (stat_in == AOK) begin
                // The M write is issued last so it wins when both target one register.
                for (int i = 0; i < NREG; i++) begin
                    if (dstE == 4'(i)) regs[i] <= valE;
                    if (dstM == 4'(i)) regs[i] <= valM;
                end
                count <= count + 64'd1;
            end else begin
                stat_reg <= stat_in;
                state    <= STOP;
                if (stat_in == HLT) count <= count + 64'd1;
            end
        end
    end

    assign stat_out    = stat_reg;
    assign halted      = (state == STOP);
    assign instr_count = count;

endmodule
